// File: rtl/pin_in_conditioner.sv
// Per-pin input conditioning: multi-flop synchronizer, stability filter and change strobe,
// plus output-pin bypass so the core sees its own drive level on pins it owns.
module pin_in_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic        clock_80,
  input  logic        inp_resn,
  input  logic [31:0] pin_in,
  input  logic [31:0] pin_out,
  input  logic [31:0] pin_dir,
  output logic [31:0] prop_in,
  output logic [31:0] pin_change
);

  localparam int unsigned CW = $clog2(FILTER_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0][31:0] r_sync;
  logic [31:0]                  r_filt;
  logic [31:0]                  r_change;
  logic [31:0][CW-1:0]          r_cnt;

  logic [31:0]                  w_sync;
  logic [31:0]                  w_filt_nxt;
  logic [31:0][CW-1:0]          w_cnt_nxt;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clock_80) begin
    if (!inp_resn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pin_in};
    end
  end

  // Counter only advances while the synchronized level disagrees with the
  // accepted one; it saturates by loading the new level, so it never wraps.
  always_comb begin
    w_filt_nxt = r_filt;
    w_cnt_nxt  = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (w_sync[i] != r_filt[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_filt_nxt[i] = w_sync[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock_80) begin
    if (!inp_resn) begin
      r_filt   <= '0;
      r_change <= '0;
      r_cnt    <= '0;
    end else begin
      r_filt   <= w_filt_nxt;
      r_change <= w_filt_nxt ^ r_filt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign prop_in    = (pin_dir & pin_out) | (~pin_dir & r_filt);
  assign pin_change = r_change;

endmodule

// File: tb/tb_pin_in_conditioner.sv
// Bench for pin_in_conditioner: window-based reference model checked every cycle,
// directed scenarios with literal expectations, and a FILTER_CYCLES=1/SYNC_STAGES=3 corner.
module tb_pin_in_conditioner;

  localparam int S  = 2;
  localparam int FC = 4;

  logic        clk = 1'b0;
  logic        resn;
  logic [31:0] pin_in, pin_out, pin_dir;
  logic [31:0] prop_in, pin_change;
  logic [31:0] p2_in;
  logic [31:0] p2_prop, p2_chg;
  logic [31:0] zero32 = '0;

  int n_cmp = 0;
  int n_err = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  pin_in_conditioner #(.SYNC_STAGES(S), .FILTER_CYCLES(FC)) dut (
    .clock_80(clk), .inp_resn(resn), .pin_in(pin_in), .pin_out(pin_out),
    .pin_dir(pin_dir), .prop_in(prop_in), .pin_change(pin_change)
  );

  pin_in_conditioner #(.SYNC_STAGES(3), .FILTER_CYCLES(1)) dut2 (
    .clock_80(clk), .inp_resn(resn), .pin_in(p2_in), .pin_out(zero32),
    .pin_dir(zero32), .prop_in(p2_prop), .pin_change(p2_chg)
  );

  // Reference: sync is the pad sampled S-1 edges ago; filt toggles when the
  // last FC synchronized values all disagree with it.
  logic [31:0] raw [S];
  logic [31:0] win [FC];
  logic [31:0] m_filt = '0;
  logic [31:0] m_chg  = '0;

  initial begin
    for (int k = 0; k < S; k++) raw[k] = '0;
    for (int k = 0; k < FC; k++) win[k] = '0;
  end

  always @(posedge clk) begin
    logic [31:0] sync_now, all_diff;
    if (!resn) begin
      for (int k = 0; k < S; k++) raw[k] = '0;
      for (int k = 0; k < FC; k++) win[k] = '0;
      m_filt = '0;
      m_chg  = '0;
    end else begin
      sync_now = raw[S-1];
      for (int k = FC - 1; k > 0; k--) win[k] = win[k-1];
      win[0] = sync_now;
      all_diff = '1;
      for (int k = 0; k < FC; k++) all_diff &= (win[k] ^ m_filt);
      m_chg  = all_diff;
      m_filt = m_filt ^ all_diff;
      for (int k = S - 1; k > 0; k--) raw[k] = raw[k-1];
      raw[0] = pin_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_prop_in", prop_in, (pin_dir & pin_out) | (~pin_dir & m_filt));
      chk("model_pin_change", pin_change, m_chg);
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic t;
    resn = 1'b0; pin_in = '0; pin_out = '0; pin_dir = '0; p2_in = '0;
    edges(1);
    cmp_en = 1'b1;
    edges(2);
    chk("reset_prop_in", prop_in, 32'h0);
    chk("reset_pin_change", pin_change, 32'h0);
    pin_dir = 32'hF0F0_0000; pin_out = 32'hA5A5_5A5A;
    #1;
    chk("reset_bypass", prop_in, 32'hA0A0_0000);
    pin_dir = '0; pin_out = '0;
    resn = 1'b1;
    edges(1);
    chk("first_edge_no_change", pin_change, 32'h0);
    edges(3);

    // clean step on pin 5
    pin_in[5] = 1'b1;
    edges(5);
    chk("step5_before", prop_in & 32'h20, 32'h0);
    edges(1);
    chk("step5_rise", prop_in & 32'h20, 32'h20);
    chk("step5_strobe", pin_change, 32'h20);
    edges(1);
    chk("step5_strobe_end", pin_change, 32'h0);

    // 3-cycle glitch rejected, 4-cycle high accepted on pin 0
    pin_in[0] = 1'b1;
    edges(3);
    pin_in[0] = 1'b0;
    edges(8);
    chk("glitch_rejected", prop_in & 32'h1, 32'h0);
    pin_in[0] = 1'b1;
    edges(4);
    pin_in[0] = 1'b0;
    edges(1);
    chk("pulse4_before", prop_in & 32'h1, 32'h0);
    edges(1);
    chk("pulse4_accepted", prop_in & 32'h1, 32'h1);
    chk("pulse4_strobe", pin_change, 32'h1);
    edges(10);

    // output-pin bypass on pin 7
    pin_dir[7] = 1'b1;
    t = 1'b0;
    for (int k = 0; k < 6; k++) begin
      t = ~t;
      pin_out[7] = t;
      #1;
      chk("bypass7", {31'h0, prop_in[7]}, {31'h0, t});
      edges(1);
    end
    pin_out[7] = 1'b1;
    pin_dir[7] = 1'b0;
    #1;
    chk("bypass7_release", {31'h0, prop_in[7]}, 32'h0);
    pin_out = '0;

    // all pins step together
    pin_in = '0;
    edges(10);
    pin_in = 32'hFFFF_FFFF;
    edges(5);
    chk("all_before", prop_in, 32'h0);
    edges(1);
    chk("all_rise", prop_in, 32'hFFFF_FFFF);
    chk("all_strobe", pin_change, 32'hFFFF_FFFF);
    edges(1);
    chk("all_strobe_end", pin_change, 32'h0);
    pin_in = '0;
    edges(10);

    // reset in the middle of a count on pin 3
    pin_in[3] = 1'b1;
    edges(4);
    resn = 1'b0;
    edges(2);
    chk("midreset_prop", prop_in, 32'h0);
    chk("midreset_chg", pin_change, 32'h0);
    resn = 1'b1;
    edges(1);
    chk("midreset_first_edge", pin_change, 32'h0);
    edges(4);
    chk("midreset_before", prop_in & 32'h8, 32'h0);
    edges(1);
    chk("midreset_rise", prop_in & 32'h8, 32'h8);
    pin_in = '0;
    edges(10);

    // pseudo-random activity checked by the model
    for (int k = 0; k < 60; k++) begin
      pin_in  = pin_in ^ ($urandom & $urandom & $urandom);
      pin_dir = $urandom;
      pin_out = $urandom;
      edges(1);
    end
    pin_dir = '0; pin_out = '0; pin_in = '0;
    edges(10);

    // corner instance: SYNC_STAGES=3, FILTER_CYCLES=1
    p2_in[9] = 1'b1;
    edges(3);
    chk("c2_step_before", p2_prop & 32'h200, 32'h0);
    edges(1);
    chk("c2_step_rise", p2_prop & 32'h200, 32'h200);
    chk("c2_step_strobe", p2_chg, 32'h200);
    p2_in = '0;
    edges(8);
    chk("c2_step_fall", p2_prop, 32'h0);
    p2_in[2] = 1'b1;
    edges(1);
    p2_in[2] = 1'b0;
    edges(2);
    chk("c2_pulse_before", p2_prop, 32'h0);
    edges(1);
    chk("c2_pulse_high", p2_prop, 32'h4);
    chk("c2_pulse_strobe", p2_chg, 32'h4);
    edges(1);
    chk("c2_pulse_low", p2_prop, 32'h0);
    chk("c2_pulse_strobe_fall", p2_chg, 32'h4);
    edges(2);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
